// File: rtl/uart_tx_cfg_pkg.sv
// Shared types and constants for the configurable UART transmitter.
// The UART_TX_BREAK_EN macro widens the interrupt vector by one flag at bit 0.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  localparam logic [1:0] DBITS_5 = 2'd0;
  localparam logic [1:0] DBITS_6 = 2'd1;
  localparam logic [1:0] DBITS_7 = 2'd2;
  localparam logic [1:0] DBITS_8 = 2'd3;

`ifdef UART_TX_BREAK_EN
  localparam int IRQ_W     = 4;
  localparam int IRQ_BREAK = 0;
  localparam int IRQ_EMPTY = 1;
  localparam int IRQ_HALF  = 2;
  localparam int IRQ_DONE  = 3;
`else
  localparam int IRQ_W     = 3;
  localparam int IRQ_EMPTY = 0;
  localparam int IRQ_HALF  = 1;
  localparam int IRQ_DONE  = 2;
`endif

  // The reserved encoding 3 behaves exactly like "no parity".
  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] bits_sel);
    case (bits_sel)
      DBITS_5: return 8'h1F;
      DBITS_6: return 8'h3F;
      DBITS_7: return 8'h7F;
      DBITS_8: return 8'hFF;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_cfg_fifo.sv
// Generic synchronous FIFO with show-ahead read data and an occupancy count.
module fifo #(
  parameter int data_size   = 8,
  parameter int buffer_size = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [data_size-1:0]         wr_data,
  input  logic                         rd_en,
  output logic [data_size-1:0]         rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(buffer_size):0] level
);

  localparam int AW = $clog2(buffer_size);

  logic [data_size-1:0] mem [buffer_size];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 do_wr;
  logic                 do_rd;

  assign full    = (count == (AW+1)'(buffer_size));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime frame format, internal baud divider, FIFO and CTS/RTS.
// Defining UART_TX_BREAK_EN adds the break_req input and a break_done interrupt flag.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int CTS_SYNC   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef UART_TX_BREAK_EN
  input  logic                          break_req,
`endif
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic [DIV_W-1:0]              cfg_baud_div,
  input  logic [IRQ_W-1:0]              irq_en,
  input  logic [IRQ_W-1:0]              irq_clr,
  input  logic                          cts_n,
  output logic                          tx,
  output logic                          rts_n,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_busy,
  output logic [IRQ_W-1:0]              irq_flags,
  output logic                          tx_irq
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0] LEVEL_HALF_PLUS1 = LVL_W'(FIFO_DEPTH / 2 + 1);
  localparam logic [LVL_W-1:0] LEVEL_ONE        = LVL_W'(1);

  logic [7:0]          fifo_rd_data;
  logic                push;
  logic                pop;
  logic [CTS_SYNC-1:0] cts_sync;
  logic                cts_s;
  logic                brk_block;
  logic                start_ok;
  logic                bit_end;
  logic                frame_end;

  logic [2:0]          state;
  logic [DIV_W-1:0]    baud_cnt;
  logic [DIV_W-1:0]    div_q;
  logic [7:0]          shift_q;
  logic [2:0]          last_bit_q;
  logic [2:0]          bit_cnt;
  logic                par_en_q;
  logic                par_bit_q;
  logic                stop2_q;
  logic                stop_cnt;

  logic [7:0]          masked_data;
  parity_e             par_mode;
  logic                par_calc;
  logic [IRQ_W-1:0]    irq_set;

  assign tx_ready = !fifo_full;
  assign push     = tx_valid && tx_ready;
  assign tx_busy  = (state != ST_IDLE);
  assign tx_irq   = |(irq_flags & irq_en);

  fifo #(
    .data_size   (8),
    .buffer_size (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Synchroniser resets to "not clear to send" so nothing leaves before CTS is seen.
  always_ff @(posedge clk) begin
    if (!rst_n) cts_sync <= '1;
    else        cts_sync <= CTS_SYNC'({cts_sync, cts_n});
  end
  assign cts_s = cts_sync[CTS_SYNC-1];

  always_ff @(posedge clk) begin
    if (!rst_n) rts_n <= 1'b1;
    else        rts_n <= fifo_full;
  end

`ifdef UART_TX_BREAK_EN
  logic brk_q;

  // A break only takes the line once the FSM is idle; a mid-frame request waits.
  always_ff @(posedge clk) begin
    if (!rst_n)                            brk_q <= 1'b0;
    else if (state == ST_IDLE && break_req) brk_q <= 1'b1;
    else if (!break_req)                   brk_q <= 1'b0;
  end
  assign brk_block = break_req || brk_q;
`else
  assign brk_block = 1'b0;
`endif

  assign start_ok  = !fifo_empty && !cts_s && !brk_block;
  assign bit_end   = (baud_cnt == div_q);
  assign frame_end = (state == ST_STOP) && bit_end && (!stop2_q || stop_cnt);
  assign pop       = start_ok && ((state == ST_IDLE) || frame_end);

  always_comb begin
    masked_data = fifo_rd_data & data_mask(cfg_data_bits);
    par_mode    = decode_parity(cfg_parity);
    par_calc    = (^masked_data) ^ (par_mode == PAR_ODD);
  end

  // Every frame starts here: the whole format is captured so later cfg writes cannot disturb it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      baud_cnt   <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      last_bit_q <= '0;
      bit_cnt    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt   <= 1'b0;
    end else if (pop) begin
      state      <= ST_START;
      tx         <= 1'b0;
      baud_cnt   <= '0;
      div_q      <= cfg_baud_div;
      shift_q    <= masked_data;
      last_bit_q <= {1'b1, cfg_data_bits};
      bit_cnt    <= '0;
      par_en_q   <= (par_mode != PAR_NONE);
      par_bit_q  <= par_calc;
      stop2_q    <= cfg_stop2;
      stop_cnt   <= 1'b0;
    end else if (state == ST_IDLE) begin
      baud_cnt <= '0;
`ifdef UART_TX_BREAK_EN
      tx       <= !break_req;
`else
      tx       <= 1'b1;
`endif
    end else begin
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      if (bit_end) begin
        case (state)
          ST_START: begin
            state   <= ST_DATA;
            bit_cnt <= '0;
            tx      <= shift_q[0];
          end
          ST_DATA: begin
            if (bit_cnt == last_bit_q) begin
              if (par_en_q) begin
                state <= ST_PARITY;
                tx    <= par_bit_q;
              end else begin
                state    <= ST_STOP;
                stop_cnt <= 1'b0;
                tx       <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift_q <= shift_q >> 1;
              tx      <= shift_q[1];
            end
          end
          ST_PARITY: begin
            state    <= ST_STOP;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
          end
          ST_STOP: begin
            if (stop2_q && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              state <= ST_IDLE;
              tx    <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

  // Push and pop in the same cycle leave the level alone, so neither flag fires then.
  always_comb begin
    irq_set            = '0;
    irq_set[IRQ_DONE]  = frame_end;
    irq_set[IRQ_HALF]  = pop && !push && (fifo_level == LEVEL_HALF_PLUS1);
    irq_set[IRQ_EMPTY] = pop && !push && (fifo_level == LEVEL_ONE);
`ifdef UART_TX_BREAK_EN
    irq_set[IRQ_BREAK] = brk_q && !break_req;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) irq_flags <= '0;
    else        irq_flags <= (irq_flags & ~irq_clr) | irq_set;
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed and randomized bench for uart_tx_cfg; frames are checked bit-by-bit
// against a list of expected line levels built from the frame format rules.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  localparam int FIFO_DEPTH = 8;
  localparam int DIV_W      = 16;
  localparam int CTS_SYNC   = 2;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rstN;
  logic [7:0]       txData;
  logic             txValid;
  logic             txReady;
  logic [1:0]       cfgDataBits;
  logic [1:0]       cfgParity;
  logic             cfgStop2;
  logic [DIV_W-1:0] cfgBaudDiv;
  logic [IRQ_W-1:0] irqEn;
  logic [IRQ_W-1:0] irqClr;
  logic             ctsN;
  logic             tx;
  logic             rtsN;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [LVL_W-1:0] fifoLevel;
  logic             txBusy;
  logic [IRQ_W-1:0] irqFlags;
  logic             txIrq;
`ifdef UART_TX_BREAK_EN
  logic             breakReq = 1'b0;
`endif

  int               checks = 0;
  int               errors = 0;
  logic [7:0]       modelQ[$];
  logic [IRQ_W-1:0] expFlags;

  always #5 clk = ~clk;

  uart_tx_cfg #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W),
    .CTS_SYNC   (CTS_SYNC)
  ) dut (
    .clk           (clk),
    .rst_n         (rstN),
`ifdef UART_TX_BREAK_EN
    .break_req     (breakReq),
`endif
    .tx_data       (txData),
    .tx_valid      (txValid),
    .tx_ready      (txReady),
    .cfg_data_bits (cfgDataBits),
    .cfg_parity    (cfgParity),
    .cfg_stop2     (cfgStop2),
    .cfg_baud_div  (cfgBaudDiv),
    .irq_en        (irqEn),
    .irq_clr       (irqClr),
    .cts_n         (ctsN),
    .tx            (tx),
    .rts_n         (rtsN),
    .fifo_full     (fifoFull),
    .fifo_empty    (fifoEmpty),
    .fifo_level    (fifoLevel),
    .tx_busy       (txBusy),
    .irq_flags     (irqFlags),
    .tx_irq        (txIrq)
  );

  // Hard stop in case something leaves the bench waiting forever.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push one byte with a single-cycle valid pulse; the model keeps what a FIFO of this depth keeps.
  task automatic applyStimulus(input logic [7:0] d);
    txValid = 1'b1;
    txData  = d;
    if (modelQ.size() < FIFO_DEPTH) modelQ.push_back(d);
    @(negedge clk);
    txValid = 1'b0;
  endtask

  task automatic setCfg(input int bitsSel, input int par, input int stop2, input int div);
    cfgDataBits = 2'(bitsSel);
    cfgParity   = 2'(par);
    cfgStop2    = 1'(stop2);
    cfgBaudDiv  = DIV_W'(div);
  endtask

  task automatic modelPop(output logic [7:0] d);
    d = modelQ.pop_front();
    if (modelQ.size() == FIFO_DEPTH / 2) expFlags[IRQ_HALF] = 1'b1;
    if (modelQ.size() == 0)              expFlags[IRQ_EMPTY] = 1'b1;
  endtask

  task automatic checkFlags(input string tag);
    checkOutput(tag, 32'(irqFlags), 32'(expFlags));
    checkOutput({tag, "Irq"}, 32'(txIrq), 32'(|(expFlags & irqEn)));
  endtask

  // Called at the negedge holding the first cycle of the start bit; returns just after the frame.
  task automatic checkFrame(input logic [7:0] d, input int nb, input int par, input int stop2,
                            input int div, input bit scramble);
    bit bits[$];
    bit x;
    x = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(d[i]);
      x = x ^ d[i];
    end
    if (par == 1) bits.push_back(x);
    if (par == 2) bits.push_back(!x);
    bits.push_back(1'b1);
    if (stop2 != 0) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c <= div; c++) begin
        if (scramble && b == 0 && c == 0)
          setCfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 7));
        checkOutput($sformatf("frameBit%0d", b), {30'b0, txBusy, tx}, {30'b0, 1'b1, bits[b]});
        @(negedge clk);
      end
    end
  endtask

  task automatic waitTxLow(input int maxCycles);
    for (int i = 0; i < maxCycles && tx !== 1'b0; i++) @(negedge clk);
    checkOutput("txStart", 32'(tx), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    int bitsSel, par, st, div;

    rstN = 1'b0; txValid = 1'b0; txData = 8'h00; ctsN = 1'b0;
    irqEn = '0; irqClr = '0; expFlags = '0;
    setCfg(3, 0, 0, 0);
    repeat (3) @(negedge clk);

    checkOutput("rstTx", 32'(tx), 32'd1);
    checkOutput("rstRts", 32'(rtsN), 32'd1);
    checkOutput("rstBusy", 32'(txBusy), 32'd0);
    checkOutput("rstFlags", 32'(irqFlags), 32'd0);
    checkOutput("rstIrq", 32'(txIrq), 32'd0);
    checkOutput("rstEmpty", 32'(fifoEmpty), 32'd1);
    checkOutput("rstFull", 32'(fifoFull), 32'd0);
    checkOutput("rstLevel", 32'(fifoLevel), 32'd0);
    rstN = 1'b1;
    repeat (CTS_SYNC + 2) @(negedge clk);

    $display("[TB] 8E1 div=3 byte A5");
    setCfg(3, 1, 0, 3);
    applyStimulus(8'hA5);
    checkOutput("pushLevel", 32'(fifoLevel), 32'd1);
    checkOutput("latencyTx", 32'(tx), 32'd1);
    @(negedge clk);
    modelPop(d);
    checkFrame(d, 8, 1, 0, 3, 1'b0);
    expFlags[IRQ_DONE] = 1'b1;
    checkFlags("flags8E1");
    irqClr = '1;
    @(negedge clk);
    irqClr = '0;
    expFlags = '0;
    checkFlags("flagsCleared");

    $display("[TB] 7O2 div=0 byte 41");
    setCfg(2, 2, 1, 0);
    applyStimulus(8'h41);
    @(negedge clk);
    modelPop(d);
    checkFrame(d, 7, 2, 1, 0, 1'b0);
    expFlags[IRQ_DONE] = 1'b1;
    checkOutput("idleAfter7O2", {30'b0, txBusy, tx}, 32'd1);

    $display("[TB] randomized frames");
    for (int k = 0; k < 6; k++) begin
      bitsSel = $urandom_range(0, 3);
      par     = $urandom_range(0, 3);
      st      = $urandom_range(0, 1);
      div     = $urandom_range(0, 4);
      d       = 8'($urandom);
      irqEn   = IRQ_W'($urandom);
      setCfg(bitsSel, par, st, div);
      applyStimulus(d);
      @(negedge clk);
      modelPop(d);
      checkFrame(d, 5 + bitsSel, par, st, div, 1'b1);
      expFlags[IRQ_DONE] = 1'b1;
      checkFlags($sformatf("randFlags%0d", k));
    end

    $display("[TB] flow control fill");
    irqClr = '1;
    ctsN   = 1'b1;
    @(negedge clk);
    irqClr = '0;
    expFlags = '0;
    irqEn  = '0;
    irqEn[IRQ_HALF] = 1'b1;
    setCfg(3, 0, 0, 1);
    repeat (CTS_SYNC + 1) @(negedge clk);
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      txValid = 1'b1;
      txData  = 8'($urandom);
      checkOutput($sformatf("ready%0d", i), 32'(txReady), 32'(modelQ.size() < FIFO_DEPTH));
      checkOutput($sformatf("holdTx%0d", i), 32'(tx), 32'd1);
      if (i == FIFO_DEPTH) checkOutput("rtsLag", 32'(rtsN), 32'd0);
      if (modelQ.size() < FIFO_DEPTH) modelQ.push_back(txData);
      @(negedge clk);
    end
    txValid = 1'b0;
    checkOutput("fullFlag", 32'(fifoFull), 32'd1);
    checkOutput("fullReady", 32'(txReady), 32'd0);
    checkOutput("fullRts", 32'(rtsN), 32'd1);
    checkOutput("fullLevel", 32'(fifoLevel), 32'(FIFO_DEPTH));
    checkOutput("fullTx", 32'(tx), 32'd1);

    $display("[TB] release CTS, back-to-back drain");
    ctsN = 1'b0;
    for (int k = 1; k <= CTS_SYNC; k++) begin
      @(negedge clk);
      checkOutput($sformatf("ctsDelay%0d", k), 32'(tx), 32'd1);
    end
    @(negedge clk);
    modelPop(d);
    for (int f = 0; f < FIFO_DEPTH; f++) begin
      checkFrame(d, 8, 0, 0, 1, 1'b0);
      expFlags[IRQ_DONE] = 1'b1;
      if (modelQ.size() > 0) modelPop(d);
      checkFlags($sformatf("drainFlags%0d", f));
      checkOutput($sformatf("drainLevel%0d", f), 32'(fifoLevel), 32'(modelQ.size()));
    end
    checkOutput("drainIdle", {30'b0, txBusy, tx}, 32'd1);

    $display("[TB] CTS raised mid-frame");
    irqClr = '1;
    ctsN   = 1'b1;
    @(negedge clk);
    irqClr = '0;
    expFlags = '0;
    repeat (CTS_SYNC + 1) @(negedge clk);
    applyStimulus(8'($urandom));
    applyStimulus(8'($urandom));
    ctsN = 1'b0;
    waitTxLow(CTS_SYNC + 4);
    ctsN = 1'b1;
    modelPop(d);
    checkFrame(d, 8, 0, 0, 1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("ctsHold%0d", k), {30'b0, txBusy, tx}, 32'd1);
      @(negedge clk);
    end
    checkOutput("ctsHoldLevel", 32'(fifoLevel), 32'(modelQ.size()));

    $display("[TB] reset mid-frame");
    ctsN = 1'b0;
    waitTxLow(CTS_SYNC + 4);
    repeat (5) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("midRstTx", 32'(tx), 32'd1);
    checkOutput("midRstLevel", 32'(fifoLevel), 32'd0);
    checkOutput("midRstBusy", 32'(txBusy), 32'd0);
    checkOutput("midRstFlags", 32'(irqFlags), 32'd0);
    rstN = 1'b1;
    modelQ.delete();
    expFlags = '0;

    $display("[TB] set beats clear");
    irqEn = '0;
    irqEn[IRQ_EMPTY] = 1'b1;
    repeat (CTS_SYNC + 2) @(negedge clk);
    applyStimulus(8'($urandom));
    @(negedge clk);
    modelPop(d);
    checkFrame(d, 8, 0, 0, 1, 1'b0);
    expFlags[IRQ_DONE] = 1'b1;
    checkFlags("emptyBefore");
    txValid = 1'b1;
    txData  = 8'($urandom);
    modelQ.push_back(txData);
    @(negedge clk);
    txValid = 1'b0;
    irqClr  = '0;
    irqClr[IRQ_EMPTY] = 1'b1;
    @(negedge clk);
    irqClr = '0;
    modelPop(d);
    checkFlags("setWins");
    checkFrame(d, 8, 0, 0, 1, 1'b0);
    irqClr[IRQ_EMPTY] = 1'b1;
    @(negedge clk);
    irqClr = '0;
    expFlags[IRQ_EMPTY] = 1'b0;
    checkFlags("plainClear");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
